// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 Local Binary Pattern core: one pixel in, one 8-bit code out per accepted
// pixel, with per-frame threshold, input stalls and an autonomous end-of-frame drain.
module lbp_stream_engine #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_image,
    input  logic [TW-1:0] in_thr,
    output logic          out_valid,
    output logic [7:0]    out_image,
    output logic          busy
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int CW    = ((DW > TW) ? DW : TW) + 1;

    localparam logic [CNT_W-1:0] LAST_PIX    = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FIRST_OUT_K = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0] N_CNT       = CNT_W'(N);
    localparam logic [COL_W-1:0] LAST_COL    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e           state_q,     state_d;
    logic [TW-1:0]    thr_q,       thr_d;
    logic [CNT_W-1:0] in_cnt_q,    in_cnt_d;
    logic [COL_W-1:0] in_col_q,    in_col_d;
    logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
    logic [COL_W-1:0] out_col_q,   out_col_d;
    logic [ROW_W-1:0] out_row_q,   out_row_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_image_q, out_image_d;

    // lb0 holds the previous row, lb1 the row before it, both indexed by column.
    logic [DW-1:0] lb0_q [IMG_W];
    logic [DW-1:0] lb0_d [IMG_W];
    logic [DW-1:0] lb1_q [IMG_W];
    logic [DW-1:0] lb1_d [IMG_W];
    // The two most recent columns of the window; the third is the column arriving now.
    logic [DW-1:0] win_q [3][2];
    logic [DW-1:0] win_d [3][2];

    logic          accept;
    logic          emit;
    logic          interior;
    logic [DW-1:0] col_new [3];
    logic [DW-1:0] nb [8];
    logic [CW-1:0] ref_val;
    logic [7:0]    lbp_code;

    // Window centred on the pixel one row up and one column left of the incoming pixel.
    always_comb begin : window_code
        col_new[0] = lb1_q[in_col_q];
        col_new[1] = lb0_q[in_col_q];
        col_new[2] = in_image;

        nb[0] = win_q[0][0];
        nb[1] = win_q[0][1];
        nb[2] = col_new[0];
        nb[3] = win_q[1][0];
        nb[4] = col_new[1];
        nb[5] = win_q[2][0];
        nb[6] = win_q[2][1];
        nb[7] = col_new[2];

        ref_val  = CW'(win_q[1][1]) + CW'(thr_q);
        lbp_code = '0;
        for (int i = 0; i < 8; i++) begin
            lbp_code[i] = (CW'(nb[i]) >= ref_val);
        end

        interior = (out_row_q != '0) && (out_row_q != LAST_ROW) &&
                   (out_col_q != '0) && (out_col_q != LAST_COL);
    end

    always_comb begin : fsm_next
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d     = state_q;
        thr_d       = thr_q;
        in_cnt_d    = in_cnt_q;
        in_col_d    = in_col_q;
        out_cnt_d   = out_cnt_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_valid_d = 1'b0;
        out_image_d = '0;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        win_d       = win_q;
        accept      = 1'b0;
        emit        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    thr_d   = in_thr;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    emit   = (in_cnt_q >= FIRST_OUT_K);
                    if (in_cnt_q == LAST_PIX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Stay one extra cycle after the last emission so busy covers the final output.
                if (out_cnt_q == N_CNT) begin
                    state_d   = S_IDLE;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = col_new[r];
            end
            lb1_d[in_col_q] = lb0_q[in_col_q];
            lb0_d[in_col_q] = in_image;
            in_cnt_d        = in_cnt_q + 1'b1;
            in_col_d        = (in_col_q == LAST_COL) ? '0 : in_col_q + 1'b1;
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_image_d = (interior && (state_q == S_RUN)) ? lbp_code : 8'h00;
            out_cnt_d   = out_cnt_q + 1'b1;
            if (out_col_q == LAST_COL) begin
                out_col_d = '0;
                out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : state_regs
        if (!rst_n) begin
            state_q     <= S_IDLE;
            thr_q       <= '0;
            in_cnt_q    <= '0;
            in_col_q    <= '0;
            out_cnt_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_image_q <= '0;
            // NOTE: buffers are cleared too; only IMG_W-deep, so the reset fan-out stays small.
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            thr_q       <= thr_d;
            in_cnt_q    <= in_cnt_d;
            in_col_q    <= in_col_d;
            out_cnt_q   <= out_cnt_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_image_q <= out_image_d;
            lb0_q       <= lb0_d;
            lb1_q       <= lb1_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_image = out_image_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Self-checking bench for lbp_stream_engine (4x4 frames): directed cases plus random frames,
// compared cycle by cycle against a frame-level LBP reference model.
module tb_lbp_stream_engine;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int TW = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_image = '0;
    logic [TW-1:0] in_thr   = '0;
    logic          out_valid;
    logic [7:0]    out_image;
    logic          busy;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         pix       [N];
    int         stall_len [N];
    logic [7:0] got       [N];

    always #5 clk = ~clk;

    lbp_stream_engine #(
        .IMG_W(W),
        .IMG_H(H),
        .DW   (DW),
        .TW   (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_image (in_image),
        .in_thr   (in_thr),
        .out_valid(out_valid),
        .out_image(out_image),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: LBP code of pixel idx in the current frame, straight from the pixel grid.
    function automatic logic [7:0] model_code(input int idx, input int thr);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int r, c;
        logic [7:0] code;
        r    = idx / W;
        c    = idx % W;
        code = 8'h00;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (pix[(r + dr[i]) * W + c + dc[i]] >= pix[idx] + thr) code[i] = 1'b1;
        end
        return code;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) begin
            pix[i]       = v;
            stall_len[i] = 0;
        end
    endtask

    // Streams pix[] (with stall_len[k] idle cycles after pixel k) and checks every cycle.
    task automatic run_frame(input int thr, input bit drop_in_drain, input string tag);
        int k = 0;
        int p = 0;
        int cyc = 0;
        int stall_left = 0;
        int acc;
        int exp_p;
        bit exp_v;
        logic [7:0] exp_c;
        while (p < N && cyc < 8 * N) begin
            acc = -1;
            if (k < N && stall_left == 0) begin
                in_valid   = 1'b1;
                in_image   = DW'(pix[k]);
                in_thr     = (k == 0) ? TW'(thr) : TW'($urandom);
                acc        = k;
                stall_left = stall_len[k];
                k++;
            end else begin
                if (stall_left > 0) stall_left--;
                in_valid = (k == N && drop_in_drain) ? 1'($urandom) : 1'b0;
                in_image = DW'($urandom);
                in_thr   = TW'($urandom);
            end
            tick();
            cyc++;
            exp_v = (acc >= W + 1) || (k == N && acc < 0);
            exp_p = (acc >= W + 1) ? acc - W - 1 : p;
            exp_c = exp_v ? model_code(exp_p, thr) : 8'h00;
            check({tag, "_valid"}, 32'(out_valid), 32'(exp_v));
            check({tag, "_code"}, 32'(out_image), 32'(exp_c));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (exp_v) begin
                got[exp_p] = out_image;
                p          = exp_p + 1;
            end
        end
        in_valid = 1'b0;
        check({tag, "_outputs"}, 32'(p), 32'(N));
        tick();
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_code", 32'(out_image), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        fill(50);
        run_frame(0, 1'b0, "flat");
        check("flat_c5", 32'(got[5]), 32'hFF);
        check("flat_c10", 32'(got[10]), 32'hFF);
        check("flat_c4", 32'(got[4]), 32'h00);

        run_frame(1, 1'b0, "flat_thr1");
        check("flat_thr1_c6", 32'(got[6]), 32'h00);

        fill(100);
        pix[5]  = 200;
        pix[0]  = 205;
        pix[10] = 201;
        run_frame(2, 1'b0, "thr2");
        check("thr2_c5", 32'(got[5]), 32'h01);

        fill(255);
        run_frame(3, 1'b0, "sat_thr3");
        check("sat_thr3_c9", 32'(got[9]), 32'h00);
        run_frame(0, 1'b0, "sat_thr0");
        check("sat_thr0_c9", 32'(got[9]), 32'hFF);

        fill(50);
        stall_len[2] = 3;
        stall_len[7] = 3;
        run_frame(0, 1'b0, "stall");
        check("stall_c9", 32'(got[9]), 32'hFF);

        fill(50);
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_image = 8'd50;
            in_thr   = '0;
            tick();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_code", 32'(out_image), 32'd0);
        tick();
        check("midrst_quiet", 32'(out_valid), 32'd0);
        run_frame(0, 1'b0, "post_rst");

        run_frame(0, 1'b1, "drop");
        run_frame(1, 1'b0, "b2b");
        check("b2b_c5", 32'(got[5]), 32'h00);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                pix[i]       = f[0] ? int'($urandom_range(120, 135)) : int'($urandom_range(0, 255));
                stall_len[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            run_frame(int'($urandom_range(0, 15)), f[0], "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
